// File: rtl/latrsnq_bank.sv
// Clocked WIDTH-bit storage bank with per-bit synchronous set/clear, load enable,
// optional output retiming pipeline and sticky/counted set-clear conflict tracking.
module latrsnq_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      STAGES    = 1,
    parameter bit               PRIORITY  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CW        = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             E,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] SETN,
    input  logic [WIDTH-1:0] CLRN,
    input  logic             CONF_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             CONFLICT,
    output logic [CW-1:0]    CONF_CNT
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] set_req;
    logic [WIDTH-1:0] clr_req;
    logic [WIDTH-1:0] force1;
    logic [WIDTH-1:0] force0;
    logic [WIDTH-1:0] load;
    logic             conflict;

    assign set_req = ~SETN;
    assign clr_req = ~CLRN;

    // Bitwise resolution rather than if/else so an X on a control input
    // propagates into the state bit instead of silently picking a branch.
    assign force1     = PRIORITY ? set_req : (set_req & ~clr_req);
    assign force0     = PRIORITY ? (clr_req & ~set_req) : clr_req;
    assign load       = {WIDTH{E}} & ~(set_req | clr_req);
    assign next_state = force1 | (load & D) | (state & ~(force0 | force1 | load));
    assign conflict   = |(set_req & clr_req);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= RESET_VAL;
        end else begin
            state <= next_state;
        end
    end

    generate
        if (STAGES == 0) begin : g_direct
            assign Q = state;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe [STAGES];

            // NOTE: every stage is reset, not just the first, so a reset
            // mid-stream can never let an older word reach Q afterwards.
            always_ff @(posedge CLK or negedge RN) begin
                if (!RN) begin
                    for (int i = 0; i < STAGES; i++) begin
                        pipe[i] <= RESET_VAL;
                    end
                end else begin
                    pipe[0] <= state;
                    for (int i = 1; i < STAGES; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign Q = pipe[STAGES-1];
        end
    endgenerate

    // A clear coinciding with a conflict keeps the new event rather than losing it.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            CONFLICT <= 1'b0;
            CONF_CNT <= '0;
        end else begin
            if (CONF_CLR) begin
                CONF_CNT <= conflict ? CW'(1) : '0;
            end else if (conflict && (CONF_CNT != CNT_MAX)) begin
                CONF_CNT <= CONF_CNT + 1'b1;
            end

            if (conflict) begin
                CONFLICT <= 1'b1;
            end else if (CONF_CLR) begin
                CONFLICT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_latrsnq_bank.sv
// Directed bench for latrsnq_bank: three parameterisations share one stimulus
// stream, each scored against its own reference model and expected-Q queue.
module tb_latrsnq_bank;

    logic       CLK = 1'b0;
    logic       RN;
    logic       E;
    logic [7:0] D;
    logic [7:0] SETN;
    logic [7:0] CLRN;
    logic       CONF_CLR;

    logic [7:0] q_a, q_b, q_c;
    logic       conflict_a, conflict_b, conflict_c;
    logic [1:0] cnt_a;
    logic [3:0] cnt_b, cnt_c;

    int checks = 0;
    int errors = 0;

    // A: STAGES=2, clear wins, RESET_VAL=A5, CW=2
    // B: STAGES=3, set wins,   RESET_VAL=5A, CW=4
    // C: STAGES=0, clear wins, RESET_VAL=00, CW=4
    localparam int         N_DUT            = 3;
    localparam bit         PRIO   [N_DUT]   = '{1'b0, 1'b1, 1'b0};
    localparam int         STG    [N_DUT]   = '{2, 3, 0};
    localparam logic [7:0] RV     [N_DUT]   = '{8'hA5, 8'h5A, 8'h00};
    localparam int         CMAX   [N_DUT]   = '{3, 15, 15};

    latrsnq_bank #(.WIDTH(8), .STAGES(2), .PRIORITY(1'b0), .RESET_VAL(8'hA5), .CW(2)) dut_a (
        .CLK(CLK), .RN(RN), .E(E), .D(D), .SETN(SETN), .CLRN(CLRN), .CONF_CLR(CONF_CLR),
        .Q(q_a), .CONFLICT(conflict_a), .CONF_CNT(cnt_a)
    );

    latrsnq_bank #(.WIDTH(8), .STAGES(3), .PRIORITY(1'b1), .RESET_VAL(8'h5A), .CW(4)) dut_b (
        .CLK(CLK), .RN(RN), .E(E), .D(D), .SETN(SETN), .CLRN(CLRN), .CONF_CLR(CONF_CLR),
        .Q(q_b), .CONFLICT(conflict_b), .CONF_CNT(cnt_b)
    );

    latrsnq_bank #(.WIDTH(8), .STAGES(0), .PRIORITY(1'b0), .RESET_VAL(8'h00), .CW(4)) dut_c (
        .CLK(CLK), .RN(RN), .E(E), .D(D), .SETN(SETN), .CLRN(CLRN), .CONF_CLR(CONF_CLR),
        .Q(q_c), .CONFLICT(conflict_c), .CONF_CNT(cnt_c)
    );

    always #5 CLK = ~CLK;

    logic [7:0] m_state [N_DUT];
    bit         m_conf  [N_DUT];
    int         m_cnt   [N_DUT];
    logic [7:0] exp_q_a [$];
    logic [7:0] exp_q_b [$];
    logic [7:0] exp_q_c [$];

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] ref_next(input logic [7:0] s, input bit prio, input logic e,
                                            input logic [7:0] d, input logic [7:0] setn,
                                            input logic [7:0] clrn);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (!setn[i] && !clrn[i]) r[i] = prio;
            else if (!clrn[i])        r[i] = 1'b0;
            else if (!setn[i])        r[i] = 1'b1;
            else if (e)               r[i] = d[i];
            else                      r[i] = s[i];
        end
        return r;
    endfunction

    task automatic push_exp(input int j, input logic [7:0] v);
        case (j)
            0:       exp_q_a.push_back(v);
            1:       exp_q_b.push_back(v);
            default: exp_q_c.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int j, output logic [7:0] v, output bit ok);
        ok = 1'b1;
        v  = 8'h00;
        case (j)
            0:       if (exp_q_a.size() == 0) ok = 1'b0; else v = exp_q_a.pop_front();
            1:       if (exp_q_b.size() == 0) ok = 1'b0; else v = exp_q_b.pop_front();
            default: if (exp_q_c.size() == 0) ok = 1'b0; else v = exp_q_c.pop_front();
        endcase
    endtask

    task automatic model_reset();
        exp_q_a.delete();
        exp_q_b.delete();
        exp_q_c.delete();
        for (int j = 0; j < N_DUT; j++) begin
            m_state[j] = RV[j];
            m_conf[j]  = 1'b0;
            m_cnt[j]   = 0;
            for (int k = 0; k < STG[j]; k++) push_exp(j, RV[j]);
        end
    endtask

    function automatic logic [7:0] obs_q(input int j);
        case (j)
            0:       return q_a;
            1:       return q_b;
            default: return q_c;
        endcase
    endfunction

    function automatic logic obs_conf(input int j);
        case (j)
            0:       return conflict_a;
            1:       return conflict_b;
            default: return conflict_c;
        endcase
    endfunction

    function automatic logic [7:0] obs_cnt(input int j);
        case (j)
            0:       return {6'd0, cnt_a};
            1:       return {4'd0, cnt_b};
            default: return {4'd0, cnt_c};
        endcase
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] v;
        bit         ok;
        for (int j = 0; j < N_DUT; j++) begin
            pop_exp(j, v, ok);
            if (!ok) begin
                checks++;
                errors++;
                $error("FAIL %s dut%0d scoreboard_empty", tag, j);
            end else begin
                check($sformatf("%s.q%0d", tag, j), obs_q(j), v);
            end
            check($sformatf("%s.conflict%0d", tag, j), {7'd0, obs_conf(j)}, {7'd0, m_conf[j]});
            check($sformatf("%s.cnt%0d", tag, j), obs_cnt(j), 8'(m_cnt[j]));
        end
    endtask

    // Drive one cycle of stimulus, advance the models, then score after the edge.
    task automatic step(input string tag, input logic e, input logic [7:0] d,
                        input logic [7:0] setn, input logic [7:0] clrn, input logic cclr);
        bit conf_cycle;
        E        = e;
        D        = d;
        SETN     = setn;
        CLRN     = clrn;
        CONF_CLR = cclr;
        conf_cycle = |(~setn & ~clrn);
        for (int j = 0; j < N_DUT; j++) begin
            m_state[j] = ref_next(m_state[j], PRIO[j], e, d, setn, clrn);
            push_exp(j, m_state[j]);
            if (cclr)                              m_cnt[j] = conf_cycle ? 1 : 0;
            else if (conf_cycle && m_cnt[j] < CMAX[j]) m_cnt[j]++;
            if (conf_cycle) m_conf[j] = 1'b1;
            else if (cclr)  m_conf[j] = 1'b0;
        end
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    // Edges with RN low: the outputs must stay at reset whatever the inputs do.
    task automatic reset_edges(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            E        = 1'($urandom);
            D        = 8'($urandom);
            SETN     = 8'($urandom);
            CLRN     = 8'($urandom);
            CONF_CLR = 1'($urandom);
            @(posedge CLK);
            #1;
            for (int j = 0; j < N_DUT; j++) begin
                check($sformatf("%s.q%0d", tag, j), obs_q(j), RV[j]);
                check($sformatf("%s.conflict%0d", tag, j), {7'd0, obs_conf(j)}, 8'd0);
                check($sformatf("%s.cnt%0d", tag, j), obs_cnt(j), 8'd0);
            end
        end
    endtask

    initial begin
        RN = 1'b0; E = 1'b0; D = 8'h00; SETN = 8'hFF; CLRN = 8'hFF; CONF_CLR = 1'b0;

        // Reset holds outputs regardless of input activity, then release and hold.
        #1;
        reset_edges("reset", 3);
        @(negedge CLK);
        RN = 1'b1;
        model_reset();
        step("hold0", 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);
        step("hold1", 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);

        // Load and observe per-instance latency, then hold.
        step("load", 1'b1, 8'h3C, 8'hFF, 8'hFF, 1'b0);
        for (int k = 0; k < 4; k++) step("load_hold", 1'b0, 8'hC3, 8'hFF, 8'hFF, 1'b0);

        // Set/clear override load, bits resolved independently.
        step("clr_all", 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0);
        step("override", 1'b1, 8'hFF, 8'h7F, 8'hFE, 1'b0);
        for (int k = 0; k < 3; k++) step("ovr_flush", 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);

        // Single-bit collision resolved by PRIORITY, then a multi-bit one counting once.
        step("coll_bit3", 1'b0, 8'h00, 8'hF7, 8'hF7, 1'b0);
        step("coll_multi", 1'b1, 8'hAA, 8'h00, 8'h0F, 1'b0);
        for (int k = 0; k < 3; k++) step("coll_flush", 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);

        // Saturation, plain clear, and clear coinciding with a conflict.
        step("cclr0", 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1);
        for (int k = 0; k < 5; k++) step("sat", 1'b0, 8'h00, 8'hFE, 8'hFE, 1'b0);
        step("cclr_plain", 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1);
        step("cclr_conf", 1'b0, 8'h00, 8'hBF, 8'hBF, 1'b1);
        step("after_cclr", 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);

        // Mixed traffic with sparse set/clear so loads still dominate.
        for (int k = 0; k < 20; k++) begin
            step("mixed", 1'($urandom), 8'($urandom),
                 8'($urandom) | 8'($urandom), 8'($urandom) | 8'($urandom),
                 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset between edges discards in-flight data.
        step("pre_abort", 1'b1, 8'h11, 8'hFF, 8'hFF, 1'b0);
        step("pre_abort1", 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);
        #2;
        RN = 1'b0;
        #1;
        for (int j = 0; j < N_DUT; j++) begin
            check($sformatf("abort_now.q%0d", j), obs_q(j), RV[j]);
            check($sformatf("abort_now.conflict%0d", j), {7'd0, obs_conf(j)}, 8'd0);
            check($sformatf("abort_now.cnt%0d", j), obs_cnt(j), 8'd0);
        end
        reset_edges("abort_hold", 4);
        @(negedge CLK);
        RN = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) step("post_abort", 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
